// File: rtl/aes_inv_key_expand_128.sv
// Iterative AES-128 inverse key schedule: loads round key 10 and
// regenerates round keys 10..0 over a valid/ready stream.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x,
                                        input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30;
    logic [7:0] x60, x120, x240, x252, inv;

    // Multiplicative inverse as a^254 (maps 0 to 0), then the affine map
    assign x2   = gmul(a, a);
    assign x3   = gmul(x2, a);
    assign x6   = gmul(x3, x3);
    assign x12  = gmul(x6, x6);
    assign x15  = gmul(x12, x3);
    assign x30  = gmul(x15, x15);
    assign x60  = gmul(x30, x30);
    assign x120 = gmul(x60, x60);
    assign x240 = gmul(x120, x120);
    assign x252 = gmul(x240, x12);
    assign inv  = gmul(x252, x2);

    assign y = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
endmodule

module aes_inv_key_expand_128 #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_last,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot, sub;
    logic [7:0]   rcon;
    logic [127:0] prev;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign p3  = w3 ^ w2;
    assign p2  = w2 ^ w1;
    assign p1  = w1 ^ w0;
    assign rot = {p3[23:0], p3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*g +: 8]),
            .y (sub[8*g +: 8])
        );
    end

    always_comb begin
        case (idx_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign p0   = w0 ^ sub ^ {rcon, 24'h000000};
    assign prev = {p0, p1, p2, p3};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_last;
                    idx_d   = 4'(NR);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (idx_q != 4'd0) begin
                        key_d = prev;
                        idx_d = idx_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign rk       = key_q;
    assign rk_idx   = idx_q;
    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q == EMIT);
    assign done     = done_q;
endmodule

// File: tb/tb_aes_inv_key_expand_128.sv
// Self-checking bench: FIPS-197 vectors plus random keys checked
// against a forward key-expansion reference model.

module tb_aes_inv_key_expand_128;
    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_last;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    aes_inv_key_expand_128 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_last (key_last),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [10:0][127:0] ks_t;
    typedef struct {
        int           idx;
        logic [127:0] key;
    } vec_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [2047:0] sbox_v;
    logic [127:0] got [0:10];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return sbox_v[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    endfunction

    // Forward AES-128 expansion: the reference all round keys come from
    function automatic ks_t expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        ks_t         ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    // Caller must be at a negedge with the DUT idle; returns at the done cycle
    task automatic run_check(input logic [127:0] kl, input ks_t exp,
                             input bit bp, input bit poke5);
        int e;
        int cyc;
        start    = 1'b1;
        key_last = kl;
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e   = 10;
        cyc = 0;
        while (e >= 0 && cyc < 300) begin
            check("valid_busy_done", {rk_valid, busy, done}, 3'b110);
            check("rk_idx", rk_idx, e[3:0]);
            check("rk", rk, exp[e]);
            got[e] = rk;
            start = poke5 && (e == 5);
            if (start) key_last = {$urandom, $urandom, $urandom, $urandom};
            rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_ready) e--;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (e >= 0) check("timeout", 1'b1, 1'b0);
        check("done_pulse", {done, busy, rk_valid}, 3'b100);
        if (!bp) check("latency", cyc, 11);
    endtask

    logic [127:0] fips_key;
    ks_t          fips_ks;
    ks_t          ks_a;
    ks_t          ks_b;
    vec_t         vecs [4];

    initial begin
        sbox_v = {
            128'h637c777bf26b6fc53001672bfed7ab76,
            128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115,
            128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84,
            128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8,
            128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973,
            128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479,
            128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
            128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df,
            128'h8ca1890dbfe6426841992d0fb054bb16};

        vecs[0] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[2] = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[3] = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

        fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_ks  = expand(fips_key);

        rst      = 1'b1;
        start    = 1'b0;
        key_last = '0;
        rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rk", rk, 128'h0);
        check("reset_idx", rk_idx, 4'd0);
        check("reset_valid", rk_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 vector, consumer always ready
        run_check(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, fips_ks, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            check($sformatf("fips_idx%0d", vecs[i].idx),
                  got[vecs[i].idx], vecs[i].key);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);

        // Same vector under random backpressure
        run_check(fips_ks[10], fips_ks, 1'b1, 1'b0);
        @(negedge clk);
        check("done_one_cycle_bp", done, 1'b0);

        // start while busy is ignored
        run_check(fips_ks[10], fips_ks, 1'b0, 1'b1);
        @(negedge clk);

        // Back-to-back: second start issued in the done cycle
        ks_a = expand({$urandom, $urandom, $urandom, $urandom});
        ks_b = expand({$urandom, $urandom, $urandom, $urandom});
        run_check(ks_a[10], ks_a, 1'b0, 1'b0);
        run_check(ks_b[10], ks_b, 1'b1, 1'b0);
        @(negedge clk);
        check("done_one_cycle_b2b", done, 1'b0);

        // Asynchronous reset in the middle of a sequence
        start    = 1'b1;
        key_last = fips_ks[10];
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_idx", rk_idx, 4'd6);
        #2 rst = 1'b1;
        #1;
        check("arst_rk", rk, 128'h0);
        check("arst_idx", rk_idx, 4'd0);
        check("arst_flags", {rk_valid, busy, done}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", {rk_valid, busy, done}, 3'b000);
        end
        run_check(fips_ks[10], fips_ks, 1'b0, 1'b0);
        @(negedge clk);

        // Random keys against the forward expansion model
        for (int n = 0; n < 6; n++) begin
            ks_a = expand({$urandom, $urandom, $urandom, $urandom});
            run_check(ks_a[10], ks_a, 1'b1, 1'b0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
